// File: rtl/alu_mc_sequencer.sv
// alu_mc_sequencer: multi-cycle sequencer that drives a combinational ALU and returns one selected result
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake; cmd_op (4b select), cmd_a/cmd_b (2b operands), cmd_key (0 add, 1 sub)
//   alu_a/alu_b/alu_sel/alu_key  registered operands/select/key driven to the ALU
//   alu_in (25b)            ALU results, LSB-anchored: [3:0] m, [5:4] d, [7:6] c, [9:8] s, [10] aeb, [11] agb,
//                           [12] alb, [13] xnor, [14] xor, [15] not4, [16] not3, [17] not2, [18] not1,
//                           [19] nor, [20] or, [21] nand, [22] and, [24:23] spare
//   rsp_valid/rsp_ready     response handshake; rsp_data (4b) selected result, zero-extended
//
// Optional feature: define ALU_SEQ_CMD_BUF_EN for a 2-entry command FIFO ahead of the FSM.
module alu_mc_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [1:0]  cmd_a,
    input  logic [1:0]  cmd_b,
    input  logic        cmd_key,
    output logic [1:0]  alu_a,
    output logic [1:0]  alu_b,
    output logic [3:0]  alu_sel,
    output logic        alu_key,
    input  logic [24:0] alu_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [3:0]  rsp_data
);
    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] sel_res;
    logic       go;
    logic [8:0] go_cmd;
    logic       unused_bits;

    assign unused_bits = ^alu_in[24:23];

`ifdef ALU_SEQ_CMD_BUF_EN
    logic [8:0] mem [2];
    logic       wp, rp, push;
    logic [1:0] fill;

    // no pass-through: a full FIFO refuses even when the head is popped this edge
    assign cmd_ready = rst_n && (fill != 2'd2);
    assign push      = cmd_valid && cmd_ready;
    assign go        = (state == IDLE) && (fill != 2'd0);
    assign go_cmd    = mem[rp];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp   <= 1'b0;
            rp   <= 1'b0;
            fill <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= {cmd_op, cmd_a, cmd_b, cmd_key};
                wp      <= ~wp;
            end
            if (go)
                rp <= ~rp;
            fill <= fill + {1'b0, push} - {1'b0, go};
        end
    end
`else
    assign cmd_ready = rst_n && (state == IDLE);
    assign go        = cmd_valid && cmd_ready;
    assign go_cmd    = {cmd_op, cmd_a, cmd_b, cmd_key};
`endif

    always_comb begin
        sel_res = 4'd0;
        case (alu_sel)
            4'd0:  sel_res = {1'b0, alu_in[10], alu_in[11], alu_in[12]};
            4'd1:  sel_res = {3'd0, alu_in[19]};
            4'd2:  sel_res = {2'd0, alu_in[5:4]};
            4'd3:  sel_res = {3'd0, alu_in[20]};
            4'd4:  sel_res = alu_in[3:0];
            4'd5:  sel_res = {3'd0, alu_in[21]};
            4'd6:  sel_res = {2'd0, alu_in[7], alu_in[9]};
            4'd7:  sel_res = {3'd0, alu_in[22]};
            4'd8:  sel_res = {3'd0, alu_in[6]};
            4'd9:  sel_res = {3'd0, alu_in[15]};
            4'd10: sel_res = {3'd0, alu_in[8]};
            4'd11: sel_res = {3'd0, alu_in[16]};
            4'd12: sel_res = {3'd0, alu_in[13]};
            4'd13: sel_res = {3'd0, alu_in[17]};
            4'd14: sel_res = {3'd0, alu_in[14]};
            default: sel_res = {3'd0, alu_in[18]};
        endcase
    end

    // The counter counts settle edges after the operand load edge, so the result is
    // sampled SETTLE_CYCLES+1 edges after the load with operands stable throughout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            alu_a     <= 2'd0;
            alu_b     <= 2'd0;
            alu_sel   <= 4'd0;
            alu_key   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 4'd0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    {alu_sel, alu_a, alu_b, alu_key} <= go_cmd;
                    cnt   <= 4'(SETTLE_CYCLES);
                    state <= SETTLE;
                end
                SETTLE: if (cnt == 4'd0) begin
                    rsp_data  <= sel_res;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc_sequencer.sv
// tb_alu_mc_sequencer: directed scoreboard bench for alu_mc_sequencer driving a behavioural 2-bit ALU
module tb_alu_mc_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_key, alu_key, rsp_valid, rsp_ready;
    logic [3:0]  cmd_op, alu_sel, rsp_data;
    logic [1:0]  cmd_a, cmd_b, alu_a, alu_b;
    logic [24:0] alu_in;
    int          total = 0;
    int          bad = 0;
    logic [3:0]  q[$];

    always #5 clk = ~clk;

    alu_mc_sequencer #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_key(cmd_key),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_key(alu_key),
        .alu_in(alu_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
    );

    function automatic logic [24:0] alu_model(input logic [1:0] a, input logic [1:0] b, input logic key);
        logic [1:0] bb, s, c, d;
        logic [3:0] m;
        logic       c0, c1;
        bb = key ? ~b : b;
        s[0] = a[0] ^ bb[0] ^ key;
        c0   = (a[0] & bb[0]) | (key & (a[0] ^ bb[0]));
        s[1] = a[1] ^ bb[1] ^ c0;
        c1   = (a[1] & bb[1]) | (c0 & (a[1] ^ bb[1]));
        c = {c1, c0};
        d = a - b;
        m = {2'd0, a} * {2'd0, b};
        return {2'b00, a[0] & b[0], ~(a[0] & b[0]), a[0] | b[0], ~(a[0] | b[0]),
                ~a[0], ~a[1], ~b[0], ~b[1], a[0] ^ b[0], ~(a[0] ^ b[0]),
                a < b, a > b, a == b, s, c, d, m};
    endfunction

    function automatic logic [3:0] exp_of(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b, input logic key);
        logic [1:0] s, c, d;
        logic [3:0] m;
        logic       lt, gt, eq;
        s = a + (key ? -b : b);
        c[0] = key ? (a[0] | ~b[0]) : (a[0] & b[0]);
        c[1] = key ? ({1'b0, a} >= {1'b0, b}) : (({1'b0, a} + {1'b0, b}) > 3'd3);
        d = a - b;
        m = a * b;
        lt = a < b;
        gt = a > b;
        eq = a == b;
        case (op)
            4'd0:  return {1'b0, eq, gt, lt};
            4'd1:  return {3'd0, ~(a[0] | b[0])};
            4'd2:  return {2'd0, d};
            4'd3:  return {3'd0, a[0] | b[0]};
            4'd4:  return m;
            4'd5:  return {3'd0, ~(a[0] & b[0])};
            4'd6:  return {2'd0, c[1], s[1]};
            4'd7:  return {3'd0, a[0] & b[0]};
            4'd8:  return {3'd0, c[0]};
            4'd9:  return {3'd0, ~b[1]};
            4'd10: return {3'd0, s[0]};
            4'd11: return {3'd0, ~b[0]};
            4'd12: return {3'd0, ~(a[0] ^ b[0])};
            4'd13: return {3'd0, ~a[1]};
            4'd14: return {3'd0, a[0] ^ b[0]};
            default: return {3'd0, ~a[0]};
        endcase
    endfunction

    assign alu_in = alu_model(alu_a, alu_b, alu_key);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (q.size() == 0)
                chk("rsp_unexpected", 32'(rsp_data), 32'hdead);
            else
                chk("rsp_data", 32'(rsp_data), 32'(q.pop_front()));
        end
    end

    task automatic issue(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b,
                         input logic key, input logic [3:0] exp, input int hold);
        int n;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_key = key; cmd_valid = 1'b1;
        rsp_ready = (hold == 0);
        n = 0;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        chk("ready_wait", 32'(n < 20), 32'd1);
        tick();
        cmd_valid = 1'b0;
        q.push_back(exp);
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        chk("latency", 32'(n), 32'd3);
        chk("alu_regs", 32'({alu_sel, alu_a, alu_b, alu_key}), 32'({op, a, b, key}));
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", 32'(rsp_data), 32'(exp));
            chk("hold_alu", 32'({alu_sel, alu_a, alu_b, alu_key}), 32'({op, a, b, key}));
`ifndef ALU_SEQ_CMD_BUF_EN
            chk("hold_ready", 32'(cmd_ready), 32'd0);
`endif
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("rsp_clear", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int n;
        logic [3:0] op;
        logic [1:0] a, b;
        logic       key;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 2'd0; cmd_b = 2'd0; cmd_key = 1'b0;
        rsp_ready = 1'b0;
        tick(); tick();
        chk("reset_ready", 32'(cmd_ready), 32'd0);
        chk("reset_outs", 32'({rsp_valid, rsp_data, alu_sel, alu_a, alu_b, alu_key}), 32'd0);
        rst_n = 1'b1;
        tick();
        issue(4'd4, 2'd3, 2'd3, 1'b0, 4'b1001, 0);
        issue(4'd0, 2'd1, 2'd2, 1'b0, 4'b0001, 0);
        issue(4'd0, 2'd2, 2'd2, 1'b0, 4'b0100, 0);
        issue(4'd6, 2'd1, 2'd1, 1'b0, 4'b0001, 0);
        issue(4'd15, 2'd2, 2'd0, 1'b0, 4'b0001, 0);
        issue(4'd2, 2'd3, 2'd1, 1'b1, 4'b0010, 5);
        for (int i = 0; i < 8; i++) begin
            op = 4'($urandom_range(0, 15)); a = 2'($urandom); b = 2'($urandom); key = 1'($urandom);
            issue(op, a, b, key, exp_of(op, a, b, key), i % 3);
        end
        // abort in SETTLE: operands nonzero so the reset clear is observable
        cmd_op = 4'd9; cmd_a = 2'd3; cmd_b = 2'd2; cmd_key = 1'b1; cmd_valid = 1'b1; rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(cmd_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        chk("abort_outs", 32'({rsp_valid, rsp_data, alu_sel, alu_a, alu_b, alu_key}), 32'd0);
        n = 0;
        for (int i = 0; i < 5; i++) begin tick(); n += 32'(rsp_valid); end
        chk("abort_no_rsp", 32'(n), 32'd0);
        issue(4'd7, 2'd3, 2'd3, 1'b0, 4'b0001, 0);
`ifdef ALU_SEQ_CMD_BUF_EN
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            op = 4'd4; a = 2'(k); b = 2'd3; key = 1'b0;
            cmd_op = op; cmd_a = a; cmd_b = b; cmd_key = key; cmd_valid = 1'b1;
            n = 0;
            while (!cmd_ready && n < 40) begin tick(); n++; end
            chk(k < 3 ? "buf_no_stall" : "buf_stall", 32'(k < 3 ? n == 0 : n > 0), 32'd1);
            tick();
            q.push_back(exp_of(op, a, b, key));
        end
        cmd_valid = 1'b0;
`endif
        n = 0;
        while (q.size() != 0 && n < 100) begin tick(); n++; end
        chk("drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
